// File: rtl/ultrasonido_pkg.sv
// Shared types and default timing for the ultrasonic ranger (50 MHz clock).
// Consumed by sensor_ultrasonido; see that file for the US_DEBOUNCE_EN option.
package ultrasonido_pkg;

    localparam int CNT_W_DEF         = 32'd22;
    localparam int TRIG_CYCLES_DEF   = 32'd500;
    localparam int ECHO_TIMEOUT_DEF  = 32'd1900000;
    localparam int PERIOD_CYCLES_DEF = 32'd3000000;
    localparam int THRESH_CYCLES_DEF = 32'd87500;
    localparam int DEBOUNCE_DEF      = 32'd2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_ECHO = 3'd2,
        MEASURE   = 3'd3,
        HOLD      = 3'd4
    } estado_t;

    // A timed-out measurement is always far; width equal to the threshold is far too.
    function automatic logic es_cercano(input logic         i_to,
                                        input logic [31:0]  i_ancho,
                                        input logic [31:0]  i_umbral);
        return (!i_to) && (i_ancho < i_umbral);
    endfunction

endpackage

// File: rtl/sincronizador.sv
// Generic two-flop synchronizer for asynchronous sensor inputs; resets to 0.
module sincronizador #(
    parameter int W = 32'd1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_ff1;
    logic [W-1:0] r_ff2;

    // Two-stage metastability filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff1 <= '0;
            r_ff2 <= '0;
        end else begin
            r_ff1 <= i_d;
            r_ff2 <= r_ff1;
        end
    end

    assign o_q = r_ff2;

endmodule

// File: rtl/sensor_ultrasonido.sv
// HC-SR04 ranger: periodic trigger, echo width measurement, presence detection.
// Define US_DEBOUNCE_EN to require DEBOUNCE agreeing measurements per presence change.
module sensor_ultrasonido
    import ultrasonido_pkg::*;
#(
    parameter int TRIG_CYCLES   = TRIG_CYCLES_DEF,
    parameter int ECHO_TIMEOUT  = ECHO_TIMEOUT_DEF,
    parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEF,
    parameter int THRESH_CYCLES = THRESH_CYCLES_DEF,
    parameter int DEBOUNCE      = DEBOUNCE_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             echo,
    output logic             trig,
    output logic             cuenta,
    output logic             presente,
    output logic [CNT_W-1:0] distancia,
    output logic             valido,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] C_TRIG_FIN = CNT_W'(TRIG_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] C_PER_FIN  = CNT_W'(PERIOD_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] C_TO       = CNT_W'(ECHO_TIMEOUT);
    localparam logic [CNT_W-1:0] C_UMBRAL   = CNT_W'(THRESH_CYCLES);

    estado_t          r_estado;
    estado_t          w_estado_nx;
    logic             w_echo_sync;
    logic             r_echo_ant;
    logic             w_sube;
    logic             w_baja;
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] r_ven;
    logic [CNT_W-1:0] r_anc;
    logic             w_trig_nx;
    logic             w_fin_med;
    logic             w_fin_to;
    logic [CNT_W-1:0] w_dist_nx;
    logic             w_cercano;

    sincronizador #(.W(32'd1)) u_sinc_echo (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (echo),
        .o_q   (w_echo_sync)
    );

    assign w_sube = w_echo_sync & ~r_echo_ant;
    assign w_baja = ~w_echo_sync & r_echo_ant;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_estado_nx;
        end
    end

    // Next-state logic; the window check uses >= because a rise may land on the last window cycle.
    always_comb begin
        w_estado_nx = r_estado;
        case (r_estado)
            IDLE: begin
                if (enable) w_estado_nx = TRIG;
                else        w_estado_nx = IDLE;
            end
            TRIG: begin
                if (r_per == C_TRIG_FIN) w_estado_nx = WAIT_ECHO;
                else                     w_estado_nx = TRIG;
            end
            WAIT_ECHO: begin
                if (w_sube)              w_estado_nx = MEASURE;
                else if (r_ven >= C_TO)  w_estado_nx = HOLD;
                else                     w_estado_nx = WAIT_ECHO;
            end
            MEASURE: begin
                if (w_baja || (r_ven >= C_TO)) w_estado_nx = HOLD;
                else                           w_estado_nx = MEASURE;
            end
            HOLD: begin
                if (r_per == C_PER_FIN) w_estado_nx = enable ? TRIG : IDLE;
                else                    w_estado_nx = HOLD;
            end
            default: w_estado_nx = IDLE;
        endcase
    end

    // Output decode: next trigger level and measurement-end qualifiers.
    always_comb begin
        w_trig_nx = (w_estado_nx == TRIG);
        w_fin_med = ((r_estado == WAIT_ECHO) || (r_estado == MEASURE)) && (w_estado_nx == HOLD);
        w_fin_to  = w_fin_med && !((r_estado == MEASURE) && w_baja);
        if (w_fin_to) w_dist_nx = C_TO;
        else          w_dist_nx = r_anc;
        w_cercano = es_cercano(w_fin_to, 32'(r_anc), 32'(C_UMBRAL));
    end

    // Period, echo window and echo width counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per      <= '0;
            r_ven      <= '0;
            r_anc      <= '0;
            r_echo_ant <= 1'b0;
        end else begin
            r_echo_ant <= w_echo_sync;
            if ((w_estado_nx == TRIG) && (r_estado != TRIG)) r_per <= '0;
            else if (r_estado != IDLE)                       r_per <= r_per + 1'b1;
            else                                             r_per <= '0;
            if ((r_estado == WAIT_ECHO) || (r_estado == MEASURE)) r_ven <= r_ven + 1'b1;
            else                                                  r_ven <= '0;
            case (r_estado)
                WAIT_ECHO: r_anc <= w_sube ? CNT_W'(1) : '0;
                MEASURE:   r_anc <= w_echo_sync ? (r_anc + 1'b1) : r_anc;
                default:   r_anc <= r_anc;
            endcase
        end
    end

    // Registered trigger and measurement results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig      <= 1'b0;
            valido    <= 1'b0;
            distancia <= '0;
            timeout   <= 1'b0;
        end else begin
            trig   <= w_trig_nx;
            valido <= w_fin_med;
            if (w_fin_med) begin
                distancia <= w_dist_nx;
                timeout   <= w_fin_to;
            end else begin
                distancia <= distancia;
                timeout   <= timeout;
            end
        end
    end

`ifdef US_DEBOUNCE_EN
    localparam int                DEB_W     = $clog2(DEBOUNCE + 32'd1);
    localparam logic [DEB_W-1:0]  C_DEB_FIN = DEB_W'(DEBOUNCE - 32'd1);
    logic [DEB_W-1:0] r_deb;

    // Presence hysteresis: DEBOUNCE consecutive disagreeing measurements flip presente.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presente <= 1'b0;
            cuenta   <= 1'b0;
            r_deb    <= '0;
        end else if (w_fin_med && (w_cercano != presente)) begin
            if (r_deb == C_DEB_FIN) begin
                presente <= w_cercano;
                cuenta   <= w_cercano;
                r_deb    <= '0;
            end else begin
                cuenta   <= 1'b0;
                r_deb    <= r_deb + 1'b1;
            end
        end else if (w_fin_med) begin
            cuenta <= 1'b0;
            r_deb  <= '0;
        end else begin
            cuenta <= 1'b0;
        end
    end
`else
    // Presence follows every measurement directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presente <= 1'b0;
            cuenta   <= 1'b0;
        end else if (w_fin_med) begin
            presente <= w_cercano;
            cuenta   <= w_cercano & ~presente;
        end else begin
            cuenta <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sensor_ultrasonido.sv
// Directed-plus-random bench for sensor_ultrasonido with a measurement-level reference model.
module tb_sensor_ultrasonido;

    localparam int TRIG_C = 10;
    localparam int TO_C   = 200;
    localparam int PER_C  = 400;
    localparam int UMB_C  = 50;
    localparam int CW     = 22;
`ifdef US_DEBOUNCE_EN
    localparam int DEB    = 2;
`else
    localparam int DEB    = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b0;
    logic          echo = 1'b0;
    logic          trig, cuenta, presente, valido, timeout;
    logic [CW-1:0] distancia;

    int checks = 0;
    int failures = 0;
    int ciclo = 0;
    int n_cuenta = 0;
    bit pres_m = 1'b0;
    int dis_m = 0;
    int cuenta_m = 0;

    sensor_ultrasonido #(
        .TRIG_CYCLES(TRIG_C), .ECHO_TIMEOUT(TO_C), .PERIOD_CYCLES(PER_C),
        .THRESH_CYCLES(UMB_C), .DEBOUNCE(2), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .echo(echo),
        .trig(trig), .cuenta(cuenta), .presente(presente),
        .distancia(distancia), .valido(valido), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ciclo <= ciclo + 1;

    always @(negedge clk) if (cuenta === 1'b1) n_cuenta <= n_cuenta + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Presence rule: DEB consecutive measurements disagreeing with presence flip it.
    task automatic modelo(input bit to, input int ancho, output bit cuenta_e);
        bit near;
        near = !to && (ancho < UMB_C);
        cuenta_e = 1'b0;
        if (near != pres_m) begin
            dis_m++;
            if (dis_m >= DEB) begin
                pres_m = near;
                dis_m = 0;
                cuenta_e = near;
            end
        end else begin
            dis_m = 0;
        end
    endtask

    task automatic esperar_trig(input logic nivel, input string tag);
        int n;
        n = 0;
        while (trig !== nivel && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(trig === nivel), 32'd1);
    endtask

    // One ranging period: echo rises `retardo` cycles after trig falls and lasts `ancho` cycles (0 = no echo).
    task automatic medir(input int retardo, input int ancho, input string tag);
        bit            to_e, c_e, visto;
        int            c;
        logic [CW-1:0] d_obs;
        logic          to_obs, pres_obs, cue_obs;
        esperar_trig(1'b1, {tag, "_trig_on"});
        esperar_trig(1'b0, {tag, "_trig_off"});
        to_e = (ancho == 0) || (retardo + ancho > 190);
        visto = 1'b0;
        c = 0;
        d_obs = '0; to_obs = 1'b0; pres_obs = 1'b0; cue_obs = 1'b0;
        while ((!visto || echo) && c < 800) begin
            if (ancho > 0 && c == retardo) echo = 1'b1;
            if (c == retardo + ancho) echo = 1'b0;
            @(negedge clk);
            if (valido === 1'b1 && !visto) begin
                visto = 1'b1;
                d_obs = distancia; to_obs = timeout; pres_obs = presente; cue_obs = cuenta;
            end
            c++;
        end
        echo = 1'b0;
        modelo(to_e, ancho, c_e);
        cuenta_m += int'(c_e);
        chk({tag, "_valido"}, 32'(visto), 32'd1);
        chk({tag, "_dist"}, 32'(d_obs), to_e ? 32'(TO_C) : 32'(ancho));
        chk({tag, "_timeout"}, 32'(to_obs), 32'(to_e));
        chk({tag, "_presente"}, 32'(pres_obs), 32'(pres_m));
        chk({tag, "_cuenta"}, 32'(cue_obs), 32'(c_e));
    endtask

    initial begin
        int n, t0, w;
        bit c_e;

        #2 rst_n = 1'b0;
        #3;
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_cuenta", 32'(cuenta), 32'd0);
        chk("rst_presente", 32'(presente), 32'd0);
        chk("rst_valido", 32'(valido), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_dist", 32'(distancia), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;

        // Trigger width and period spacing.
        esperar_trig(1'b1, "p_trig_on");
        t0 = ciclo;
        n = 0;
        while (trig === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("trig_alto", 32'(n), 32'(TRIG_C));
        esperar_trig(1'b1, "p_trig_on2");
        chk("periodo", 32'(ciclo - t0), 32'(PER_C));

        // Near object twice, then stays near.
        medir(5, 30, "cerca1");
        medir(8, 30, "cerca2");
        medir(int'($urandom_range(2, 20)), int'($urandom_range(5, 45)), "cerca3");
        medir(int'($urandom_range(2, 20)), int'($urandom_range(5, 45)), "cerca4");

        // No echo: timeouts clear presence.
        medir(0, 0, "sin_eco1");
        medir(0, 0, "sin_eco2");

        // Threshold boundary, overlong echo, then normal resumption.
        medir(4, 50, "umbral");
        medir(3, 250, "eco_largo");
        medir(int'($urandom_range(2, 20)), int'($urandom_range(5, 45)), "reanuda");

        // Alternating far/near never reaches the debounce count.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) medir(int'($urandom_range(2, 20)), int'($urandom_range(55, 150)), "alt_lejos");
            else            medir(int'($urandom_range(2, 20)), int'($urandom_range(5, 45)), "alt_cerca");
        end

        // Random mix.
        for (int i = 0; i < 6; i++) begin
            w = int'($urandom_range(0, 150));
            medir(int'($urandom_range(2, 20)), w, "mezcla");
        end
        chk("n_cuenta_a", 32'(n_cuenta), 32'(cuenta_m));

        // Reset in the middle of a measurement with presence asserted.
        medir(5, 20, "pre_rst1");
        medir(5, 20, "pre_rst2");
        esperar_trig(1'b1, "r_trig_on");
        esperar_trig(1'b0, "r_trig_off");
        repeat (3) @(negedge clk);
        echo = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_trig", 32'(trig), 32'd0);
        chk("rmid_cuenta", 32'(cuenta), 32'd0);
        chk("rmid_presente", 32'(presente), 32'd0);
        chk("rmid_valido", 32'(valido), 32'd0);
        chk("rmid_dist", 32'(distancia), 32'd0);
        echo = 1'b0;
        pres_m = 1'b0;
        dis_m = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (trig !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reinicio", 32'(n <= 3 && trig === 1'b1), 32'd1);
        medir(5, 25, "post_rst1");
        medir(5, 25, "post_rst2");

        // Dropping enable lets the current period finish, then ranging stops.
        esperar_trig(1'b1, "en_trig_on");
        enable = 1'b0;
        n = 0;
        while (trig === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("en_trig_alto", 32'(n), 32'(TRIG_C));
        n = 0;
        while (valido !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        modelo(1'b1, 0, c_e);
        cuenta_m += int'(c_e);
        chk("en_valido", 32'(valido), 32'd1);
        chk("en_presente", 32'(presente), 32'(pres_m));
        n = 0;
        while (trig !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("en_sin_trig", 32'(trig), 32'd0);
        enable = 1'b1;
        esperar_trig(1'b1, "en_reanuda");
        chk("n_cuenta_fin", 32'(n_cuenta), 32'(cuenta_m));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
